conv_tree_result_collector: RTL and testbench

//  Receiving end of the conv-tree stream. The feeder launches skewed input beats into ArrayTop.

---
 rtl/conv_tree_result_collector.sv | 147 ++++++++++++++
 tb/tb_conv_tree_result_collector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tree_result_collector.sv
// conv_tree_result_collector
// Receiving end of the conv-tree stream. After a start pulse it waits the
// configured tree path latency, then captures one DATA_W result per cycle from
// the selected dataOut lane into a small register buffer (optional ReLU) and
// re-emits each captured result as a valid-qualified stream.
//
// Stream handshake: res_valid qualifies res_data/res_idx for exactly one cycle
// per captured result. There is no ready input; the consumer must take every
// beat in the cycle it is presented.
//
// state_dbg mirrors the FSM state (0 IDLE, 1 WAIT, 2 CAPTURE, 3 DONE).
module conv_tree_result_collector #(
    parameter int DATA_W    = 16,
    parameter int N_LANES   = 9,
    parameter int BUF_DEPTH = 16,
    parameter int LAT_W     = 4,
    parameter int CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LAT_W-1:0]          lat_cfg,
    input  logic [CNT_W-1:0]          n_cfg,
    input  logic [3:0]                lane_sel,
    input  logic                      relu_en,
    input  logic [DATA_W*N_LANES-1:0] data_out_in,
    output logic                      res_valid,
    output logic [DATA_W-1:0]         res_data,
    output logic [CNT_W-1:0]          res_idx,
    input  logic [CNT_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err_start,
    output logic [1:0]                state_dbg
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [LAT_W-1:0]   wcnt;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   wr_idx;
    logic [3:0]         lane_q;
    logic               relu_q;
    logic [DATA_W-1:0]  buffer [BUF_DEPTH];

    logic [LAT_W-1:0]   lat_eff;
    logic [CNT_W-1:0]   n_eff;
    logic [3:0]         lane_eff;
    logic [DATA_W-1:0]  lane_val;
    logic [DATA_W-1:0]  store_val;
    logic               capture;

    // Normalise the start-time configuration: latency of 0 behaves as 1,
    // oversize run length clamps to the buffer depth, bad lane falls back to 0.
    always_comb begin
        lat_eff  = (lat_cfg == '0) ? LAT_W'(1) : lat_cfg;
        n_eff    = (n_cfg > CNT_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH) : n_cfg;
        lane_eff = (lane_sel >= 4'(N_LANES)) ? 4'd0 : lane_sel;
    end

    // Lane mux plus ReLU on the latched lane/relu settings.
    always_comb begin
        lane_val = data_out_in[DATA_W-1:0];
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_q == 4'(i)) begin
                lane_val = data_out_in[i*DATA_W +: DATA_W];
            end
        end
        store_val = (relu_q && lane_val[DATA_W-1]) ? '0 : lane_val;
    end

    // The last WAIT edge already captures, so the first result lands exactly
    // lat_eff edges after the start edge even for a latency of 1.
    assign capture = ((state == S_WAIT) && (wcnt == '0)) || (state == S_CAPTURE);

    assign busy      = (state == S_WAIT) || (state == S_CAPTURE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // Asynchronous read port; a same-cycle write is seen only after the edge.
    assign rd_data = (rd_addr < CNT_W'(BUF_DEPTH)) ? buffer[rd_addr[AW-1:0]] : '0;

    // Control FSM, config latches, result buffer and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            n_q       <= '0;
            wr_idx    <= '0;
            lane_q    <= '0;
            relu_q    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            err_start <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= n_eff;
                        lane_q    <= lane_eff;
                        relu_q    <= relu_en;
                        err_start <= 1'b0;
                        wr_idx    <= '0;
                        wcnt      <= lat_eff - LAT_W'(1);
                        state     <= (n_eff == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (start) err_start <= 1'b1;
                    if (wcnt != '0) wcnt <= wcnt - LAT_W'(1);
                end
                S_CAPTURE: begin
                    if (start) err_start <= 1'b1;
                end
                S_DONE: begin
                    if (start) err_start <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (capture) begin
                buffer[wr_idx[AW-1:0]] <= store_val;
                res_valid <= 1'b1;
                res_data  <= store_val;
                res_idx   <= wr_idx;
                wr_idx    <= wr_idx + CNT_W'(1);
                state     <= (wr_idx == n_q - CNT_W'(1)) ? S_DONE : S_CAPTURE;
            end
        end
    end

endmodule

// File: tb/tb_conv_tree_result_collector.sv
// Directed bench for conv_tree_result_collector. Inputs change 1 ns after each
// rising edge; outputs are observed at that same point, after they settled.
module tb_conv_tree_result_collector;

    localparam int DW = 16;
    localparam int NL = 9;
    localparam int CW = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [3:0]        lat_cfg;
    logic [CW-1:0]     n_cfg;
    logic [3:0]        lane_sel;
    logic              relu_en;
    logic [DW*NL-1:0]  data_out_in;
    logic              res_valid;
    logic [DW-1:0]     res_data;
    logic [CW-1:0]     res_idx;
    logic [CW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              done;
    logic              err_start;
    logic [1:0]        state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] t1_vals [4];

    conv_tree_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lat_cfg     (lat_cfg),
        .n_cfg       (n_cfg),
        .lane_sel    (lane_sel),
        .relu_en     (relu_en),
        .data_out_in (data_out_in),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_idx     (res_idx),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .err_start   (err_start),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] v);
        for (int i = 0; i < NL; i++) begin
            data_out_in[i*DW +: DW] = 16'($urandom_range(0, 65535));
        end
        if (lane < NL) data_out_in[lane*DW +: DW] = v;
    endtask

    task automatic launch(input logic [3:0] lat, input logic [CW-1:0] n,
                          input logic [3:0] lane, input logic relu);
        lat_cfg  = lat;
        n_cfg    = n;
        lane_sel = lane;
        relu_en  = relu;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic check_cap(input string tag, input logic [15:0] d, input logic [CW-1:0] idx);
        check({tag, " valid"}, 32'(res_valid), 32'd1);
        check({tag, " data"}, 32'(res_data), 32'(d));
        check({tag, " idx"}, 32'(res_idx), 32'(idx));
    endtask

    task automatic rd_check(input string tag, input logic [CW-1:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; lat_cfg = '0; n_cfg = '0; lane_sel = '0;
        relu_en = 1'b0; data_out_in = '0; rd_addr = '0;
        t1_vals[0] = 16'd2376; t1_vals[1] = 16'd3240;
        t1_vals[2] = 16'd3240; t1_vals[3] = 16'd4104;
        step(); step();

        // ---- reset state
        check("rst valid", 32'(res_valid), 0);
        check("rst data", 32'(res_data), 0);
        check("rst idx", 32'(res_idx), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err_start), 0);
        check("rst state", 32'(state_dbg), 0);
        rd_check("rst rd0", 5'd0, 16'd0);
        rst = 1'b1;
        step();

        // ---- 1) 2x2 tree: lat 6, n 4, lane 2
        launch(4'd6, 5'd4, 4'd2, 1'b0);
        check("t1 busy", 32'(busy), 1);
        check("t1 state wait", 32'(state_dbg), 1);
        for (int j = 1; j <= 5; j++) begin
            set_lane(2, 16'h7777);
            step();
            check($sformatf("t1 no valid k+%0d", j), 32'(res_valid), 0);
        end
        for (int i = 0; i < 4; i++) begin
            set_lane(2, t1_vals[i]);
            step();
            check_cap($sformatf("t1 cap%0d", i), t1_vals[i], 5'(i));
        end
        check("t1 done", 32'(done), 1);
        check("t1 busy at done", 32'(busy), 0);
        step();
        check("t1 done drop", 32'(done), 0);
        check("t1 valid drop", 32'(res_valid), 0);
        for (int i = 0; i < 4; i++) rd_check($sformatf("t1 buf%0d", i), 5'(i), t1_vals[i]);

        // ---- 2) lat 0 and lat 1 behave the same
        launch(4'd0, 5'd2, 4'd0, 1'b0);
        check("t2a no valid k", 32'(res_valid), 0);
        set_lane(0, 16'h0A0A); step();
        check_cap("t2a cap0", 16'h0A0A, 5'd0);
        set_lane(0, 16'h0B0B); step();
        check_cap("t2a cap1", 16'h0B0B, 5'd1);
        check("t2a done", 32'(done), 1);
        step();
        launch(4'd1, 5'd2, 4'd0, 1'b0);
        check("t2b no valid k", 32'(res_valid), 0);
        set_lane(0, 16'h0C0C); step();
        check_cap("t2b cap0", 16'h0C0C, 5'd0);
        set_lane(0, 16'h0D0D); step();
        check_cap("t2b cap1", 16'h0D0D, 5'd1);
        check("t2b done", 32'(done), 1);
        step();

        // ---- 3) start during WAIT, start during DONE
        launch(4'd3, 5'd2, 4'd1, 1'b0);
        start = 1'b1; set_lane(1, 16'h0BAD); step(); start = 1'b0;
        check("t3 err in wait", 32'(err_start), 1);
        check("t3 still busy", 32'(busy), 1);
        set_lane(1, 16'h0BAD); step();
        check("t3 no early valid", 32'(res_valid), 0);
        set_lane(1, 16'd11); step();
        check_cap("t3 cap0", 16'd11, 5'd0);
        set_lane(1, 16'd22); step();
        check_cap("t3 cap1", 16'd22, 5'd1);
        check("t3 done", 32'(done), 1);
        step();
        launch(4'd1, 5'd1, 4'd1, 1'b0);
        check("t3 err cleared", 32'(err_start), 0);
        set_lane(1, 16'd33); step();
        check_cap("t3 run2 cap", 16'd33, 5'd0);
        check("t3 run2 done", 32'(done), 1);
        start = 1'b1; step(); start = 1'b0;
        check("t3 err in done", 32'(err_start), 1);
        check("t3 done start ignored", 32'(busy), 0);
        step();
        check("t3 idle after ignore", 32'(state_dbg), 0);

        // ---- 4) ReLU on and off
        launch(4'd1, 5'd2, 4'd3, 1'b1);
        check("t4 err cleared", 32'(err_start), 0);
        set_lane(3, 16'hFFF6); step();
        check_cap("t4 relu cap0", 16'h0000, 5'd0);
        set_lane(3, 16'd5); step();
        check_cap("t4 relu cap1", 16'd5, 5'd1);
        step();
        rd_check("t4 relu buf0", 5'd0, 16'h0000);
        rd_check("t4 relu buf1", 5'd1, 16'd5);
        launch(4'd1, 5'd2, 4'd3, 1'b0);
        set_lane(3, 16'hFFF6);
        rd_check("t4 old value before write", 5'd0, 16'h0000);
        step();
        check_cap("t4 raw cap0", 16'hFFF6, 5'd0);
        check("t4 rd after write", 32'(rd_data), 32'h0000FFF6);
        set_lane(3, 16'd5); step();
        check_cap("t4 raw cap1", 16'd5, 5'd1);
        step();

        // ---- 5) reset during CAPTURE
        launch(4'd1, 5'd4, 4'd0, 1'b0);
        set_lane(0, 16'h1111); step();
        check_cap("t5 cap0", 16'h1111, 5'd0);
        set_lane(0, 16'h2222); step();
        check_cap("t5 cap1", 16'h2222, 5'd1);
        rst = 1'b0; set_lane(0, 16'h3333); step();
        check("t5 rst valid", 32'(res_valid), 0);
        check("t5 rst data", 32'(res_data), 0);
        check("t5 rst idx", 32'(res_idx), 0);
        check("t5 rst busy", 32'(busy), 0);
        check("t5 rst done", 32'(done), 0);
        rd_check("t5 rst buf0", 5'd0, 16'd0);
        rd_check("t5 rst buf1", 5'd1, 16'd0);
        rd_check("t5 rst buf3", 5'd3, 16'd0);
        rst = 1'b1; step();
        check("t5 no done after rst", 32'(done), 0);
        launch(4'd2, 5'd1, 4'd0, 1'b0);
        set_lane(0, 16'h0BAD); step();
        check("t5 wait no valid", 32'(res_valid), 0);
        set_lane(0, 16'h1234); step();
        check_cap("t5 rerun cap", 16'h1234, 5'd0);
        check("t5 rerun done", 32'(done), 1);
        step();

        // ---- 6) n=0, n clamp, lane clamp
        launch(4'd5, 5'd0, 4'd0, 1'b0);
        check("t6 n0 done", 32'(done), 1);
        check("t6 n0 busy", 32'(busy), 0);
        check("t6 n0 valid", 32'(res_valid), 0);
        step();
        check("t6 n0 done drop", 32'(done), 0);
        check("t6 n0 valid after", 32'(res_valid), 0);
        launch(4'd1, 5'd20, 4'd12, 1'b0);
        for (int i = 0; i < 16; i++) begin
            set_lane(0, 16'(100 + i*7)); step();
            check_cap($sformatf("t6 cap%0d", i), 16'(100 + i*7), 5'(i));
        end
        check("t6 done after 16", 32'(done), 1);
        set_lane(0, 16'hEEEE); step();
        check("t6 no 17th", 32'(res_valid), 0);
        check("t6 idle", 32'(busy), 0);
        rd_check("t6 buf15", 5'd15, 16'd205);
        rd_check("t6 rd16 zero", 5'd16, 16'd0);
        rd_check("t6 rd31 zero", 5'd31, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
